// File: rtl/st_packet_rr_arbiter.sv
// st_packet_rr_arbiter: packet-aware round-robin merge of NUM_IN
// Avalon-ST byte sources onto one registered, channelized output.
module st_packet_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHAN_W-1:0]        out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    input  logic [NUM_IN-1:0]        src_enable,
    input  logic                     err_clear,
    output logic                     busy,
    output logic [2:0]               grant_id,
    output logic                     err_orphan
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        last_grant;
    logic [NUM_IN-1:0] cand;
    logic              any_cand;
    logic              hi_found;
    logic              lo_found;
    logic [2:0]        hi_win;
    logic [2:0]        lo_win;
    logic [2:0]        winner;
    logic              load;
    logic              accept;
    logic              orphan;
    logic [DATA_W-1:0] g_data;
    logic              g_sop;
    logic              g_eop;

    assign load     = out_ready | ~out_valid;
    assign cand     = in_valid & in_startofpacket & src_enable;
    assign any_cand = |cand;
    assign busy     = (state == PKT);
    assign winner   = hi_found ? hi_win : lo_win;

    // Round-robin search: first candidate above last_grant, else wrap.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cand[i] && i > int'(last_grant) && !hi_found) begin
                hi_found = 1'b1;
                hi_win   = 3'(i);
            end
            if (cand[i] && i <= int'(last_grant) && !lo_found) begin
                lo_found = 1'b1;
                lo_win   = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: grant on any SOP candidate, release on accepted EOP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_cand) state_nxt = PKT;
            PKT:     if (accept && g_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: orphan drain while idle, granted-source mux while in a packet.
    always_comb begin
        in_ready = '0;
        accept   = 1'b0;
        orphan   = 1'b0;
        g_data   = '0;
        g_sop    = 1'b0;
        g_eop    = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (state == IDLE) begin
                if (src_enable[i] && in_valid[i] && !in_startofpacket[i]) begin
                    in_ready[i] = 1'b1;
                    orphan      = 1'b1;
                end
            end else if (3'(i) == grant_id) begin
                in_ready[i] = load;
                accept      = in_valid[i] & load;
                g_data      = in_data[i*DATA_W +: DATA_W];
                g_sop       = in_startofpacket[i];
                g_eop       = in_endofpacket[i];
            end
        end
    end

    // Grant bookkeeping; last_grant resets so source 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= 3'(NUM_IN - 1);
        end else begin
            if (state == IDLE && any_cand) grant_id <= winner;
            if (accept && g_eop)           last_grant <= grant_id;
        end
    end

    // Single output stage: load on accept, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else if (accept) begin
            out_valid         <= 1'b1;
            out_data          <= g_data;
            out_channel       <= CHAN_W'(grant_id);
            out_startofpacket <= g_sop;
            out_endofpacket   <= g_eop;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

    // Sticky orphan flag; a new drop wins over a clear.
    always_ff @(posedge clk) begin
        if (reset)          err_orphan <= 1'b0;
        else if (orphan)    err_orphan <= 1'b1;
        else if (err_clear) err_orphan <= 1'b0;
    end

endmodule

// File: doc/st_packet_rr_arbiter.md
Name: st_packet_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that merges NUM_IN Avalon-ST byte-stream sources into one channelized Avalon-ST stream.
- The output channel field carries the index of the winning source.
- The block sits upstream of the trace fabric's host-to-target channel adapter and feeds its "in" interface.
- A grant is held for a whole packet, SOP to EOP. The output is a single registered stage.

Parameters:
- NUM_IN, 4, number of source ports (2..8).
- DATA_W, 8, data width per beat.
- CHAN_W, 8, out_channel width; must be >= clog2(NUM_IN). Upper bits are zero-filled.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-source valid.
- in_data  in  NUM_IN*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-source SOP.
- in_endofpacket  in  NUM_IN  per-source EOP.
- in_ready  out  NUM_IN  per-source ready.
- out_ready  in  1  downstream ready.
- out_valid  out  1  output valid.
- out_data  out  DATA_W  output data.
- out_channel  out  CHAN_W  granted source index.
- out_startofpacket  out  1  output SOP.
- out_endofpacket  out  1  output EOP.
- src_enable  in  NUM_IN  per-source arbitration enable.
- err_clear  in  1  clears err_orphan.
- busy  out  1  high while in PKT state.
- grant_id  out  3  current or last granted index.
- err_orphan  out  1  sticky flag: a non-SOP beat was dropped while IDLE.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high, named reset.
- Reset values: out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, busy=0, grant_id=0, err_orphan=0, state=IDLE, last_grant=NUM_IN-1 (so source 0 has first priority).
- Reset mid-packet: the packet is abandoned and any held output beat is discarded. No EOP is emitted.
- load = out_ready | ~out_valid. This is the output register's ability to take a beat.
- State IDLE:
  - Candidates = in_valid & in_startofpacket & src_enable.
  - Winner = the first candidate at or after (last_grant+1) mod NUM_IN, searched in increasing index with wrap.
  - If any candidate exists: the next state is PKT, grant_id = winner, and busy goes high next cycle.
  - No in_ready is asserted for candidates in IDLE. The SOP beat is accepted in PKT, which gives one arbitration cycle.
  - Orphan drain: for each enabled source with in_valid=1 and in_startofpacket=0, in_ready=1 in IDLE. The beat is discarded and err_orphan is set.
  - Disabled sources always see in_ready=0.
- State PKT:
  - in_ready[grant_id] = load. All other in_ready = 0. There is no orphan drain.
  - On an accepted beat (in_valid[g] & in_ready[g]), the output register loads data, SOP, EOP, out_channel=g and out_valid=1.
  - If there is no accepted beat and out_ready=1, out_valid clears.
  - Accepted beat with EOP=1: next state IDLE, last_grant=g, busy=0.
  - Single-beat packets (SOP=EOP=1) are legal.
  - A mid-packet SOP on the granted source is forwarded unchanged; no correction is made.
- src_enable is sampled only at arbitration. Deasserting it mid-packet does not truncate the current packet.
- Output latency: a beat accepted in cycle N appears on out_valid in cycle N+1. Throughput is 1 beat/cycle while out_ready stays high.
- Back-to-back packets: EOP is accepted in cycle N, IDLE arbitration happens in N+1, and the next SOP is accepted in N+2. This leaves a one-cycle bubble between packets.
- Output stability: out_* stay stable while out_valid=1 and out_ready=0. This follows from load=0 blocking in_ready.
- err_orphan:
  - Set has priority over err_clear in the same cycle.
  - Clears only on err_clear=1 with no orphan drain that cycle.
- Round-robin fairness: with all sources continuously requesting, grants rotate 0,1,2,3,0,...

Test Plan:
- Reset then one packet: source 2 sends a 3-beat packet (0xA1 SOP, 0xA2, 0xA3 EOP) with out_ready=1 -> out_channel=2. Data A1/A2/A3 appears with SOP on the first beat and EOP on the last. The first out_valid occurs 2 cycles after in_valid. busy falls after the EOP beat.
- Fairness: all 4 sources continuously send 2-beat packets -> grant order 0,1,2,3,0,1 with no source skipped. Each packet is contiguous on the output with no interleaving.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet from source 1 -> out_data held stable while stalled, no beat lost or duplicated, in_ready[1]=0 during stall cycles.
- Orphan: in IDLE, source 3 presents valid without SOP, data 0x55 -> in_ready[3]=1, nothing appears on the output, err_orphan=1. Pulsing err_clear then gives err_orphan=0.
- Enable mask: src_enable=4'b1101 with sources 1 and 2 requesting -> source 2 is granted and source 1 is never granted. Clearing src_enable[2] mid-packet -> the packet still completes through EOP.
- Reset mid-packet: assert reset after beat 2 of 4 -> all outputs are 0 next cycle. The next packet is from source 0 with the lowest-index priority restored.
